// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and status-byte layout.
// The status bit indices match the top-level status mux and the uart_tx side.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int STATUS_RX_AVAIL = 6;
  localparam int STATUS_OVERRUN  = 5;
  localparam int STATUS_FERR     = 4;

  // Bit 1 (txready) stays 0 here; the top level ORs it in.
  function automatic logic [7:0] status_byte(input logic avail, input logic ovr, input logic ferr);
    logic [7:0] s;
    s = '0;
    s[STATUS_RX_AVAIL] = avail;
    s[STATUS_OVERRUN]  = ovr;
    s[STATUS_FERR]     = ferr;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers, combinational head and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with an input synchroniser, byte FIFO and 6502 bus data/status registers.
// dout is zero outside read cycles so the top level can OR it with other peripherals.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int TB_W    = 14,
  parameter int FIFO_AW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [TB_W-1:0] timebase,
  input  logic            rxin,
  input  logic            sel,
  input  logic            addr0,
  input  logic            rd,
  output logic [7:0]      dout,
  output logic            rx_avail
);

  localparam logic [TB_W-1:0] CNT_ONE = 1;

  rx_state_t        state;
  rx_state_t        state_next;
  logic             rx_meta;
  logic             rx_s;
  logic [TB_W-1:0]  cnt;
  logic             tick;
  logic [2:0]       bitcnt;
  logic [7:0]       shift;
  logic             push;
  logic             ferr_set;
  logic             overrun;
  logic             ferr;
  logic             data_rd;
  logic             status_rd;
  logic             pop;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic [FIFO_AW:0] count;

  assign tick      = (cnt == '0);
  assign data_rd   = rd && sel && !addr0;
  assign status_rd = rd && sel && addr0;
  assign pop       = data_rd && !empty;
  assign rx_avail  = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxin;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!rx_s) state_next = ST_START;
      ST_START: if (tick) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && bitcnt == 3'd7) state_next = ST_STOP;
      ST_STOP:  if (tick) state_next = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    if (state == ST_STOP && tick) begin
      push     = rx_s;
      ferr_set = !rx_s;
    end
  end

  // Half-bit preload on the start edge puts every later tick near mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (!rx_s) cnt <= timebase >> 1;
        ST_START, ST_DATA, ST_STOP: begin
          cnt <= tick ? timebase : cnt - CNT_ONE;
          if (state == ST_START && tick) bitcnt <= '0;
          if (state == ST_DATA && tick) begin
            shift[bitcnt] <= rx_s;
            bitcnt        <= bitcnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (shift),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky flags clear on a status read, but a set in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (push && full && !pop) overrun <= 1'b1;
      else if (status_rd)       overrun <= 1'b0;
      if (ferr_set)             ferr <= 1'b1;
      else if (status_rd)       ferr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          dout <= '0;
    else if (data_rd)   dout <= empty ? 8'h00 : head;
    else if (status_rd) dout <= status_byte(rx_avail, overrun, ferr);
    else                dout <= '0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bit-accurate serial driver, queue-based reference model,
// and a monitor that compares dout against queued expectations the cycle after each access.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [13:0] timebase;
  logic        rxin;
  logic        sel;
  logic        addr0;
  logic        rd;
  logic [7:0]  dout;
  logic        rx_avail;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_q [$];
  bit         m_ovr  = 1'b0;
  bit         m_ferr = 1'b0;

  logic [7:0] exp_q  [$];
  bit         kind_q [$];

  bit   mon_en = 1'b0;
  logic acc_q  = 1'b0;

  uart_rx_fifo #(.TB_W(14), .FIFO_AW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .timebase (timebase),
    .rxin     (rxin),
    .sel      (sel),
    .addr0    (addr0),
    .rd       (rd),
    .dout     (dout),
    .rx_avail (rx_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  always @(posedge clk) acc_q <= rd & sel;

  // Monitor: a bus access last cycle must match the oldest expectation; otherwise dout is zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (acc_q) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_read: got %02h expected no access", dout);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          automatic bit         k = kind_q.pop_front();
          check_output(k ? "status_read" : "data_read", dout, e);
        end
      end else begin
        check_output("dout_idle", dout, 8'h00);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int stop_cycle(input int t);
    return 3 + (t >> 1) + 9 * (t + 1);
  endfunction

  task automatic bus_access(input bit a0);
    rd = 1'b1; sel = 1'b1; addr0 = a0;
    @(posedge clk);
    #1;
    rd = 1'b0; sel = 1'b0; addr0 = 1'b0;
  endtask

  task automatic read_data();
    logic [7:0] e;
    e = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
    exp_q.push_back(e);
    kind_q.push_back(1'b0);
    bus_access(1'b0);
  endtask

  task automatic read_status();
    logic [7:0] e;
    e = {1'b0, model_q.size() != 0, m_ovr, m_ferr, 4'b0000};
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    exp_q.push_back(e);
    kind_q.push_back(1'b1);
    bus_access(1'b1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop, input int extra_low);
    int bc;
    bc = int'(timebase) + 1;
    rxin = 1'b0;
    wait_cycles(bc);
    for (int i = 0; i < 8; i++) begin
      rxin = b[i];
      wait_cycles(bc);
    end
    rxin = stop;
    wait_cycles(bc + extra_low);
    rxin = 1'b1;
    wait_cycles(4);
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop, input int extra_low);
    drive_frame(b, stop, extra_low);
    if (!stop) m_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic check_avail(input string name);
    check_output(name, {7'b0, rx_avail}, {7'b0, model_q.size() != 0});
  endtask

  initial begin
    reset = 1'b1; rxin = 1'b1; sel = 1'b0; addr0 = 1'b0; rd = 1'b0;
    timebase = 14'd233;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    mon_en = 1'b1;
    check_output("reset_dout", dout, 8'h00);
    check_avail("reset_avail");

    $display("[TB] empty reads after reset");
    read_status();
    read_data();
    wait_cycles(2);

    $display("[TB] single frame 0x55 with push latency");
    fork
      rx_frame(8'h55, 1'b1, 0);
      begin
        repeat (stop_cycle(233)) @(posedge clk);
        #1;
        check_output("avail_at_stop_tick", {7'b0, rx_avail}, 8'h00);
        @(posedge clk);
        #1;
        check_output("avail_after_stop_tick", {7'b0, rx_avail}, 8'h01);
      end
    join
    read_status();
    read_data();
    check_avail("avail_after_pop");

    $display("[TB] framing error with line held low");
    rx_frame(8'hA5, 1'b0, 3 * 234);
    check_avail("avail_after_ferr");
    read_status();
    read_status();

    $display("[TB] overrun with nine frames");
    for (int i = 1; i <= 9; i++) rx_frame(8'(i), 1'b1, 0);
    read_status();
    for (int i = 0; i < 8; i++) read_data();
    check_avail("avail_after_drain");
    read_status();

    $display("[TB] start glitch");
    rxin = 1'b0;
    wait_cycles(50);
    rxin = 1'b1;
    wait_cycles(3 * 234);
    read_status();
    check_avail("avail_after_glitch");

    $display("[TB] reset mid-frame");
    rx_frame(8'h77, 1'b1, 0);
    check_avail("avail_preload");
    fork
      drive_frame(8'h3C, 1'b1, 0);
      begin
        wait_cycles(3 * 234);
        reset = 1'b1;
        wait_cycles(8 * 234);
        reset = 1'b0;
      end
    join
    model_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    wait_cycles(2);
    check_avail("avail_after_reset");
    read_status();
    rx_frame(8'hC3, 1'b1, 0);
    read_data();

    $display("[TB] full fifo with pop on stop tick");
    for (int i = 0; i < DEPTH; i++) rx_frame(8'h80 + 8'(i), 1'b1, 0);
    fork
      rx_frame(8'hE7, 1'b1, 0);
      begin
        repeat (stop_cycle(233)) @(posedge clk);
        #1;
        read_data();
      end
    join
    read_status();
    for (int i = 0; i < DEPTH; i++) read_data();
    check_avail("avail_after_full_drain");

    $display("[TB] randomized frames at faster timebase");
    timebase = 14'd40;
    wait_cycles(4);
    for (int f = 0; f < 12; f++) begin
      automatic logic [7:0] b = 8'($urandom);
      automatic bit stop = ($urandom_range(0, 7) != 0);
      automatic int nrd = $urandom_range(0, 3);
      rx_frame(b, stop, 0);
      for (int r = 0; r < nrd; r++) begin
        if ($urandom_range(0, 1) != 0) read_data();
        else read_status();
      end
    end
    read_status();
    for (int i = 0; i < DEPTH + 1; i++) read_data();
    check_avail("avail_final");

    wait_cycles(3);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
